// File: rtl/edm_pulse_scheduler.sv
// edm_pulse_scheduler
// Runs the EDM discharge pulse train as repeating ON/OFF periods timed in units of
// CLK_PER_UNIT clocks. New Ton/Toff/Ip values are staged when they arrive and take effect
// only at the next period start. Completed periods are counted for the feedback path.
//
// Ports
//   clk, rst                    : system clock, synchronous active-high reset
//   machine_start_ack/stop_ack  : start/stop requests (rising edge is the event)
//   Ton_data/change_Ton_ack     : ON time in units, staged on the ack rising edge
//   Toff_data/change_Toff_ack   : OFF time in units, staged on the ack rising edge
//   Ip_data/change_Ip_ack       : peak current setpoint, staged on the ack rising edge
//   pulse_on                    : gate enable, high during ON
//   ip_setpoint                 : Ip in use for the current period
//   running                     : high while a pulse train is active
//   feedback_data               : completed-period count
//   change_feedback_ack         : one-cycle strobe when feedback_data updates
module edm_pulse_scheduler #(
  parameter int unsigned CLK_PER_UNIT = 216
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        machine_start_ack,
  input  logic        machine_stop_ack,
  input  logic [15:0] Ton_data,
  input  logic        change_Ton_ack,
  input  logic [15:0] Toff_data,
  input  logic        change_Toff_ack,
  input  logic [15:0] Ip_data,
  input  logic        change_Ip_ack,
  output logic        pulse_on,
  output logic [15:0] ip_setpoint,
  output logic        running,
  output logic [31:0] feedback_data,
  output logic        change_feedback_ack
);

  localparam int unsigned PreW = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_PER_UNIT - 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e          r_state, w_state_d;
  logic [4:0]      r_ack_prev;
  logic [4:0]      w_ack, w_ev;
  logic [15:0]     r_ton_stg, r_toff_stg, r_ip_stg;
  logic [15:0]     w_ton_stg_d, w_toff_stg_d, w_ip_stg_d;
  logic [15:0]     r_ton_act, r_toff_act, r_ip_act;
  logic [PreW-1:0] r_pre, w_pre_d;
  logic [15:0]     r_unit, w_unit_d, w_limit;
  logic [31:0]     r_feedback, w_feedback_d;
  logic            r_fb_ack, w_fb_ack_d;
  logic            r_pulse_on, r_running;
  logic            w_load, w_last;

  // Bit order: start, stop, Ton, Toff, Ip
  assign w_ack = {machine_start_ack, machine_stop_ack, change_Ton_ack, change_Toff_ack,
                  change_Ip_ack};
  assign w_ev  = w_ack & ~r_ack_prev;

  always_comb begin
    // Staging bypass: a change arriving on a period-start edge is used for that period
    w_ton_stg_d  = w_ev[2] ? Ton_data  : r_ton_stg;
    w_toff_stg_d = w_ev[1] ? Toff_data : r_toff_stg;
    w_ip_stg_d   = w_ev[0] ? Ip_data   : r_ip_stg;

    w_state_d    = r_state;
    w_load       = 1'b0;
    w_feedback_d = r_feedback;
    w_fb_ack_d   = 1'b0;
    w_limit      = (r_state == StOn) ? r_ton_act : r_toff_act;
    w_last       = (r_pre == PreMax) && (r_unit == w_limit - 16'd1);

    if (r_pre == PreMax) begin
      w_pre_d  = '0;
      w_unit_d = r_unit + 16'd1;
    end else begin
      w_pre_d  = r_pre + PreW'(1);
      w_unit_d = r_unit;
    end

    unique case (r_state)
      StIdle: begin
        if (w_ev[4]) begin
          w_load       = 1'b1;
          w_feedback_d = '0;
          w_state_d    = (w_ton_stg_d != 16'd0) ? StOn : StOff;
        end
      end
      StOn: begin
        if (w_last) w_state_d = StOff;
      end
      StOff: begin
        if (w_last) begin
          w_load       = 1'b1;
          w_feedback_d = r_feedback + 32'd1;
          w_fb_ack_d   = 1'b1;
          w_state_d    = (w_ton_stg_d != 16'd0) ? StOn : StOff;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Stop beats everything, including a simultaneous start or a period completion
    if (w_ev[3]) begin
      w_state_d    = StIdle;
      w_load       = 1'b0;
      w_feedback_d = r_feedback;
      w_fb_ack_d   = 1'b0;
    end

    // Timers restart on every state entry (including OFF->OFF when Ton is 0) and sit at 0
    // in IDLE
    if (w_load || (w_state_d != r_state) || (w_state_d == StIdle)) begin
      w_pre_d  = '0;
      w_unit_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_ack_prev <= '0;
      r_ton_stg  <= 16'd80;
      r_toff_stg <= 16'd20;
      r_ip_stg   <= 16'd30;
      r_ton_act  <= 16'd80;
      r_toff_act <= 16'd20;
      r_ip_act   <= 16'd30;
      r_pre      <= '0;
      r_unit     <= '0;
      r_feedback <= '0;
      r_fb_ack   <= 1'b0;
      r_pulse_on <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_ack_prev <= w_ack;
      r_ton_stg  <= w_ton_stg_d;
      r_toff_stg <= w_toff_stg_d;
      r_ip_stg   <= w_ip_stg_d;
      if (w_load) begin
        r_ton_act  <= w_ton_stg_d;
        r_toff_act <= (w_toff_stg_d == 16'd0) ? 16'd1 : w_toff_stg_d;
        r_ip_act   <= w_ip_stg_d;
      end
      r_pre      <= w_pre_d;
      r_unit     <= w_unit_d;
      r_feedback <= w_feedback_d;
      r_fb_ack   <= w_fb_ack_d;
      r_pulse_on <= (w_state_d == StOn);
      r_running  <= (w_state_d != StIdle);
    end
  end

  assign pulse_on            = r_pulse_on;
  assign running             = r_running;
  assign ip_setpoint         = r_ip_act;
  assign feedback_data       = r_feedback;
  assign change_feedback_ack = r_fb_ack;

endmodule

// File: tb/tb_edm_pulse_scheduler.sv
// Testbench for edm_pulse_scheduler: directed scenarios followed by randomized traffic,
// checked against a period-level reference model (phase + remaining-cycle count).
module tb_edm_pulse_scheduler;

  localparam int CPU = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_ack = 1'b0, stop_ack = 1'b0;
  logic [15:0] ton_d = '0, toff_d = '0, ip_d = '0;
  logic        ton_ack = 1'b0, toff_ack = 1'b0, ip_ack = 1'b0;
  logic        pulse_on, running, fb_ack;
  logic [15:0] ip_sp;
  logic [31:0] fb_data;

  edm_pulse_scheduler #(.CLK_PER_UNIT(CPU)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .machine_start_ack   (start_ack),
    .machine_stop_ack    (stop_ack),
    .Ton_data            (ton_d),
    .change_Ton_ack      (ton_ack),
    .Toff_data           (toff_d),
    .change_Toff_ack     (toff_ack),
    .Ip_data             (ip_d),
    .change_Ip_ack       (ip_ack),
    .pulse_on            (pulse_on),
    .ip_setpoint         (ip_sp),
    .running             (running),
    .feedback_data       (fb_data),
    .change_feedback_ack (fb_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // Reference model state
  int          m_phase = 0;  // 0 idle, 1 on, 2 off
  int          m_rem   = 0;  // clocks left in the current phase
  logic [4:0]  m_prev  = '0;
  int          m_ton_s = 80, m_toff_s = 20, m_ip_s = 30;
  int          m_ton_a = 80, m_toff_a = 20, m_ip_a = 30;
  logic [31:0] m_count = '0;
  bit          m_strobe = 1'b0;

  typedef struct {int at; logic [31:0] val;} fb_exp_t;
  fb_exp_t fb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic start_period();
    m_ton_a  = m_ton_s;
    m_toff_a = (m_toff_s == 0) ? 1 : m_toff_s;
    m_ip_a   = m_ip_s;
    if (m_ton_a != 0) begin
      m_phase = 1;
      m_rem   = m_ton_a * CPU;
    end else begin
      m_phase = 2;
      m_rem   = m_toff_a * CPU;
    end
  endtask

  // One clock edge of the reference, using the inputs held across that edge
  task automatic model_edge();
    logic [4:0] now, ev;
    now = {start_ack, stop_ack, ton_ack, toff_ack, ip_ack};
    ev  = now & ~m_prev;
    m_strobe = 1'b0;
    if (rst) begin
      m_prev = '0; m_phase = 0; m_rem = 0; m_count = '0;
      m_ton_s = 80; m_toff_s = 20; m_ip_s = 30;
      m_ton_a = 80; m_toff_a = 20; m_ip_a = 30;
      return;
    end
    m_prev = now;
    if (ev[2]) m_ton_s  = int'(ton_d);
    if (ev[1]) m_toff_s = int'(toff_d);
    if (ev[0]) m_ip_s   = int'(ip_d);
    if (ev[3]) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (ev[4]) begin
        m_count = '0;
        start_period();
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_phase == 1) begin
          m_phase = 2;
          m_rem   = m_toff_a * CPU;
        end else begin
          m_count  = m_count + 32'd1;
          m_strobe = 1'b1;
          fb_q.push_back('{at: cyc + 1, val: m_count});
          start_period();
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compare registered outputs mid-cycle; strobes are matched against the queue
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pulse_on", {31'd0, pulse_on}, {31'd0, m_phase == 1});
      chk("running", {31'd0, running}, {31'd0, m_phase != 0});
      chk("ip_setpoint", {16'd0, ip_sp}, 32'(m_ip_a));
      chk("feedback_data", fb_data, m_count);
      if (fb_ack === 1'b1) begin
        if (fb_q.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          fb_exp_t e;
          e = fb_q.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(e.at));
          chk("strobe_data", fb_data, e.val);
        end
      end else if (fb_q.size() != 0 && fb_q[0].at <= cyc) begin
        fb_exp_t e;
        e = fb_q.pop_front();
        chk("missing_strobe", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic set_ton(input int v);
    ton_d = 16'(v); ton_ack = 1'b1; tick(); ton_ack = 1'b0;
  endtask
  task automatic set_toff(input int v);
    toff_d = 16'(v); toff_ack = 1'b1; tick(); toff_ack = 1'b0;
  endtask
  task automatic set_ip(input int v);
    ip_d = 16'(v); ip_ack = 1'b1; tick(); ip_ack = 1'b0;
  endtask
  task automatic do_stop();
    stop_ack = 1'b1; tick(); stop_ack = 1'b0; tick();
  endtask
  task automatic do_start(input int hold);
    start_ack = 1'b1; ticks(hold); start_ack = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    ticks(2);
    rst = 1'b0;
    tick();

    // Basic train: Ton=3, Toff=2, start held 7 cycles, three full periods
    set_ton(3);
    set_toff(2);
    do_start(7);
    ticks(60);

    // Mid-ON Ton change to 5 and Ip change to 50 take effect at the next boundary
    ticks(3);
    set_ton(5);
    set_ip(50);
    ticks(60);

    // Stop 5 cycles into ON, then restart (count cleared), then stop again
    do_stop();
    set_ton(3);
    do_start(1);
    ticks(4);
    do_stop();
    ticks(3);
    do_start(2);
    ticks(30);

    // Start while running is ignored
    do_start(3);
    ticks(25);
    do_stop();

    // Ton=0, Toff=0: no ON phase, OFF clamped to one unit
    set_ton(0);
    set_toff(0);
    do_start(1);
    ticks(20);
    do_stop();

    // Start and stop rising together from IDLE
    start_ack = 1'b1; stop_ack = 1'b1;
    tick();
    start_ack = 1'b0; stop_ack = 1'b0;
    ticks(4);

    // Change event on the same edge as the period start uses the new value
    ton_d = 16'd2; ton_ack = 1'b1; start_ack = 1'b1;
    tick();
    ton_ack = 1'b0; start_ack = 1'b0;
    ticks(3);

    // Preload the count to all-ones during ON, then let the period complete
    force dut.r_feedback = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_feedback;
    ticks(20);

    // Reset mid-OFF
    set_toff(4);
    ticks(12);
    while (m_phase != 2) tick();
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(3);

    // Randomized traffic
    ton_d = 16'd2; toff_d = 16'd1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ton_d = 16'($urandom_range(0, 5)); ton_ack = ~ton_ack;
      end
      if ($urandom_range(0, 7) == 0) begin
        toff_d = 16'($urandom_range(0, 4)); toff_ack = ~toff_ack;
      end
      if ($urandom_range(0, 7) == 0) begin
        ip_d = 16'($urandom); ip_ack = ~ip_ack;
      end
      if ($urandom_range(0, 40) == 0) start_ack = ~start_ack;
      if ($urandom_range(0, 150) == 0) stop_ack = ~stop_ack;
      rst = ($urandom_range(0, 1500) == 0);
      tick();
    end
    rst = 1'b0;
    ticks(2);

    chk("queue_drained", 32'(fb_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edm_pulse_scheduler.md
# edm_pulse_scheduler

Sequences the discharge pulse train from the parameters delivered by the SPI command decoder. It consumes the decoder's start/stop and parameter-change acknowledges and runs an ON/OFF period state machine timed in units of `CLK_PER_UNIT` clock cycles. Parameter changes are applied only at period boundaries. It returns a completed-pulse count to the decoder's feedback path and sits between the SPI command block and the gate-drive/current-setpoint logic.

## Interface
- `CLK_PER_UNIT`, default 216: clk cycles per Ton/Toff unit (1 µs at 216 MHz); legal range ≥ 2.
- `clk`  in  1: system clock (216 MHz domain).
- `rst`  in  1: synchronous reset, active-high.
- `machine_start_ack`  in  1: start request; level held ≥ 1 cycle, rising edge is the event.
- `machine_stop_ack`  in  1: stop request; rising edge is the event.
- `Ton_data`  in  16: ON time in units.
- `change_Ton_ack`  in  1: rising edge stages `Ton_data`.
- `Toff_data`  in  16: OFF time in units.
- `change_Toff_ack`  in  1: rising edge stages `Toff_data`.
- `Ip_data`  in  16: peak current setpoint.
- `change_Ip_ack`  in  1: rising edge stages `Ip_data`.
- `pulse_on`  out  1: gate enable, high during ON.
- `ip_setpoint`  out  16: active Ip, stable for the whole period.
- `running`  out  1: high while not IDLE.
- `feedback_data`  out  32: completed-pulse count.
- `change_feedback_ack`  out  1: one-cycle strobe when `feedback_data` updates.

## Operation
- Edge detection: each ack input is registered once; event = current sample high AND previous sample low. An ack held high for several cycles is one event.
- Staging registers:
  - `ton_stg`/`toff_stg`/`ip_stg` load from the data input on the corresponding change event, in any state.
  - Reset values are 80, 20 and 30.
- Active registers:
  - `ton_act`/`toff_act`/`ip_act` copy the staging registers at every period start, i.e. on IDLE→ON/OFF and on OFF→next period.
  - If a change event occurs in the same cycle as a period start, the new data is used for that period (staging bypass).
- Clamping: `toff_act` = max(`toff_stg`, 1), so there is always a minimum off time. `ton_act` = 0 is legal and means a period with no ON phase.
- States IDLE, ON, OFF:
  - IDLE: start event → ON if `ton` ≠ 0, else OFF. A load of the active registers accompanies the transition.
  - ON: after `ton_act`×`CLK_PER_UNIT` cycles → OFF.
  - OFF: after `toff_act`×`CLK_PER_UNIT` cycles, `feedback_data`++ (wraps 0xFFFFFFFF→0), `change_feedback_ack` strobes, active registers reload, and the next period begins (ON, or OFF if the new `ton` = 0).
  - Any state: stop event → IDLE. `pulse_on` drops at that edge; the aborted period is not counted.
- Simultaneous start and stop events: stop wins, and the state is IDLE.
- A start event outside IDLE is ignored. A stop event in IDLE is ignored.
- Start event from IDLE clears `feedback_data` to 0; no strobe is issued.
- Timers:
  - A prescaler counts 0..`CLK_PER_UNIT`−1.
  - A 16-bit unit counter counts units and compares against the active value.
  - Both counters clear on every state entry.
- `ip_setpoint` = `ip_act`; it changes only at period starts.
- Reset: `pulse_on`=0, `running`=0, `ip_setpoint`=30, `feedback_data`=0, `change_feedback_ack`=0, state IDLE, edge registers 0.

## Timing
- All outputs are registered.
- Start latency: the edge that first samples `machine_start_ack`=1 (previous sample 0) enters ON; `pulse_on`=1 and `running`=1 from that edge.
- ON width is exactly `ton_act`×`CLK_PER_UNIT` cycles. OFF width is exactly `toff_act`×`CLK_PER_UNIT` cycles.
- Period = (`ton_act`+`toff_act`)×`CLK_PER_UNIT` cycles, with no dead cycle between periods.
- `change_feedback_ack` is high for 1 cycle, coincident with the first cycle of the next period; `feedback_data` is already updated in that cycle.
- Stop latency: the edge that samples the stop event sets `pulse_on`=0 and `running`=0.
- Max unit count is 65535 units, so the internal cycle count fits 16 + clog2(`CLK_PER_UNIT`) bits; no overflow is permitted.
- Reset mid-period forces the reset values at the next edge, regardless of state.

## Test plan
- `CLK_PER_UNIT`=4, Ton=3, Toff=2, start ack held 7 cycles → `pulse_on` high 12 cycles, low 8, repeating; exactly one period started; `feedback_data` 1, 2, 3 with one-cycle strobes every 20 cycles.
- Running with Ton=3; Ton=5 change event issued mid-ON → current period keeps 12-cycle ON; next period has 20-cycle ON. Ip change 30→50 applies only at the next boundary.
- Stop event 5 cycles into ON → `pulse_on`=0 and `running`=0 on that edge; `feedback_data` unchanged; a second start clears the count to 0 and restarts.
- Ton=0, Toff=0 → `pulse_on` never asserts; OFF is clamped to 4 cycles; `feedback_data` increments every 4 cycles.
- Start and stop rising in the same cycle from IDLE → stays IDLE, `pulse_on`=0. Start while running → ignored, timing undisturbed.
- Preload `feedback_data` path to 0xFFFFFFFF (force count), complete one period → wraps to 0 with strobe. Assert `rst` mid-OFF → all outputs at reset values next cycle.
